// File: rtl/var_delay_pipe.sv
// var_delay_pipe
//   Runtime-programmable delay line for hash-pipeline operands. NUM_LANES data
//   lanes share one valid bit. The delay (active_depth) can be changed only
//   while the pipe is empty, so entries already in flight keep their latency.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   enable        1 = pipeline advances this edge, 0 = all state holds
//   flush         synchronous clear of every in-flight entry (beats enable)
//   delay_sel     requested delay in enabled cycles (clamped to 1..MAX_DEPTH)
//   in_valid      input entry present
//   in_data       lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid     delayed entry present
//   out_data      delayed data, all-zero when out_valid = 0
//   occupancy     number of valid entries in the active stages
//   active_depth  delay currently in force
module var_delay_pipe #(
  parameter int MAX_DEPTH   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LANES   = 2,
  parameter int RESET_DELAY = 8,
  parameter int DSEL_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            flush,
  input  logic [DSEL_W-1:0]               delay_sel,
  input  logic                            in_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [DSEL_W-1:0]               occupancy,
  output logic [DSEL_W-1:0]               active_depth
);

  localparam int W     = NUM_LANES * DATA_WIDTH;
  localparam int RST_D = (RESET_DELAY < 1) ? 1 :
                         ((RESET_DELAY > MAX_DEPTH) ? MAX_DEPTH : RESET_DELAY);
  localparam logic [DSEL_W-1:0] RST_DEPTH = DSEL_W'(RST_D);

  function automatic logic [DSEL_W-1:0] clamp_depth(input logic [DSEL_W-1:0] sel);
    if (sel == '0)
      return DSEL_W'(1);
    if (int'(sel) > MAX_DEPTH)
      return DSEL_W'(MAX_DEPTH);
    return sel;
  endfunction

  logic         vld_p [MAX_DEPTH];
  logic [W-1:0] dat_p [MAX_DEPTH];
  logic [W-1:0] sel_dat;

  // Control path: valid bits, occupancy and depth. Depth reloads only when the
  // pre-edge occupancy is zero, so a delay change waits for the pipe to drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_DEPTH; k++)
        vld_p[k] <= 1'b0;
      occupancy    <= '0;
      active_depth <= RST_DEPTH;
    end else begin
      if (occupancy == '0)
        active_depth <= clamp_depth(delay_sel);
      if (flush) begin
        for (int k = 0; k < MAX_DEPTH; k++)
          vld_p[k] <= 1'b0;
        occupancy <= '0;
      end else if (enable) begin
        vld_p[0] <= in_valid;
        for (int k = 1; k < MAX_DEPTH; k++)
          vld_p[k] <= (DSEL_W'(k) >= active_depth) ? 1'b0 : vld_p[k-1];
        // out_valid here is the pre-edge value of the entry leaving the pipe
        occupancy <= occupancy + DSEL_W'(in_valid) - DSEL_W'(out_valid);
      end
    end
  end

  // Data path: no reset; invalid stages are loaded with zero and the output is
  // gated by valid, so stale data never reaches out_data.
  always_ff @(posedge clock) begin
    if (flush) begin
      for (int k = 0; k < MAX_DEPTH; k++)
        dat_p[k] <= '0;
    end else if (enable) begin
      dat_p[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < MAX_DEPTH; k++)
        dat_p[k] <= (DSEL_W'(k) >= active_depth) ? '0 : dat_p[k-1];
    end
  end

  // Output tap: register-only mux at stage active_depth-1
  always_comb begin
    out_valid = 1'b0;
    sel_dat   = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DSEL_W'(k + 1) == active_depth) begin
        out_valid = vld_p[k];
        sel_dat   = dat_p[k];
      end
    end
    out_data = out_valid ? sel_dat : '0;
  end

endmodule
